// File: rtl/pipe_phy_ctrl_responder.sv
// PHY-side PIPE control responder: answers MAC powerdown/rate changes and
// receiver-detect requests with programmable-latency PhyStatus/RxStatus handshakes.
module pipe_phy_ctrl_responder #(
    parameter int LANES         = 4,
    parameter int PHYSTATUS_DLY = 8,
    parameter int RXDET_DLY     = 16,
    parameter int RST_HOLD      = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           pipe_powerdown,
    input  logic [LANES*2-1:0]   pipe_rate,
    input  logic [LANES-1:0]     pipe_txdetectrxloopback,
    input  logic [LANES-1:0]     pipe_txelecidle,
    input  logic [LANES-1:0]     rx_present,
    output logic [LANES-1:0]     pipe_phystatus,
    output logic [LANES*3-1:0]   pipe_rxstatus,
    output logic                 busy
);

    if (PHYSTATUS_DLY < 1 || PHYSTATUS_DLY > 255) begin : g_bad_phystatus_dly
        $error("PHYSTATUS_DLY must be in 1..255");
    end
    if (RXDET_DLY < 1 || RXDET_DLY > 255) begin : g_bad_rxdet_dly
        $error("RXDET_DLY must be in 1..255");
    end
    if (RST_HOLD < 1 || RST_HOLD > 255) begin : g_bad_rst_hold
        $error("RST_HOLD must be in 1..255");
    end

    localparam logic [7:0] PHY_DLY8  = 8'(PHYSTATUS_DLY);
    localparam logic [7:0] DET_DLY8  = 8'(RXDET_DLY);
    localparam logic [7:0] HOLD_CNT8 = 8'(RST_HOLD);
    localparam logic [2:0] PD_P1     = 3'b010;

    typedef enum logic [1:0] {S_RST_HOLD, S_IDLE, S_WAIT, S_PULSE} state_t;

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 is_rxdet_q, is_rxdet_d;
    logic [2:0]           pd_acc_q, pd_acc_d;
    logic [LANES*2-1:0]   rate_acc_q, rate_acc_d;
    logic                 rxdet_armed_q, rxdet_armed_d;
    logic [LANES-1:0]     phystatus_q, phystatus_d;
    logic [LANES*3-1:0]   rxstatus_q, rxstatus_d;
    logic                 busy_q, busy_d;
    logic [LANES*3-1:0]   det_status;

    // Only lane 0 carries the detect request and electrical-idle qualifier.
    logic unused_upper_lanes;
    assign unused_upper_lanes = &{1'b0, pipe_txdetectrxloopback[LANES-1:1],
                                  pipe_txelecidle[LANES-1:1]};

    always_comb begin
        det_status = '0;
        for (int n = 0; n < LANES; n++) begin
            det_status[3*n +: 3] = rx_present[n] ? 3'b011 : 3'b000;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        is_rxdet_d    = is_rxdet_q;
        pd_acc_d      = pd_acc_q;
        rate_acc_d    = rate_acc_q;
        rxdet_armed_d = rxdet_armed_q | ~pipe_txdetectrxloopback[0];
        phystatus_d   = '0;
        rxstatus_d    = '0;

        case (state_q)
            S_RST_HOLD: begin
                phystatus_d = '1;
                if (cnt_q == HOLD_CNT8) begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    phystatus_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_IDLE: begin
                if (pipe_powerdown != pd_acc_q) begin
                    pd_acc_d   = pipe_powerdown;
                    cnt_d      = PHY_DLY8;
                    is_rxdet_d = 1'b0;
                    state_d    = S_WAIT;
                end else if (pipe_rate != rate_acc_q) begin
                    rate_acc_d = pipe_rate;
                    cnt_d      = PHY_DLY8;
                    is_rxdet_d = 1'b0;
                    state_d    = S_WAIT;
                end else if (rxdet_armed_q && pipe_txdetectrxloopback[0] &&
                             pipe_txelecidle[0] && pipe_powerdown == PD_P1) begin
                    rxdet_armed_d = 1'b0;
                    cnt_d         = DET_DLY8;
                    is_rxdet_d    = 1'b1;
                    state_d       = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d     = S_PULSE;
                    phystatus_d = '1;
                    rxstatus_d  = is_rxdet_q ? det_status : '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_PULSE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_RST_HOLD;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_RST_HOLD;
            cnt_q         <= '0;
            is_rxdet_q    <= 1'b0;
            pd_acc_q      <= PD_P1;
            rate_acc_q    <= '0;
            rxdet_armed_q <= 1'b1;
            phystatus_q   <= '1;
            rxstatus_q    <= '0;
            busy_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            is_rxdet_q    <= is_rxdet_d;
            pd_acc_q      <= pd_acc_d;
            rate_acc_q    <= rate_acc_d;
            rxdet_armed_q <= rxdet_armed_d;
            phystatus_q   <= phystatus_d;
            rxstatus_q    <= rxstatus_d;
            busy_q        <= busy_d;
        end
    end

    assign pipe_phystatus = phystatus_q;
    assign pipe_rxstatus  = rxstatus_q;
    assign busy           = busy_q;

endmodule
